// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS bidirectional 8-bit I/O ports with per-bit direction,
// two-flop input synchronisers, edge flags (write-1-to-clear) and a combined interrupt.
module io_port_bank #(
  parameter logic [15:0] BASE_ADDR = 16'h8400,
  parameter int          NUM_PORTS = 2,
  parameter int          EDGE_MODE = 0
) (
  input  logic                   cpu_clk,
  input  logic                   reset,
  input  logic [15:0]            addr,
  input  logic [7:0]             data_in,
  input  logic                   write_enable,
  output logic [7:0]             data_out,
  output logic                   hit,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [8*NUM_PORTS-1:0] port_dir,
  output logic                   irq
);

  localparam int        W    = 8 * NUM_PORTS;
  localparam logic [3:0] NP_W = 4'(NUM_PORTS);

  logic [W-1:0]         out_r;
  logic [W-1:0]         dir_r;
  logic [W-1:0]         flag_r;
  logic [W-1:0]         ien_r;
  logic [W-1:0]         sync1_r;
  logic [W-1:0]         sync_r;
  logic [W-1:0]         prev_r;
  logic [1:0]           settle_r;

  logic                 sel_s;
  logic [NUM_PORTS-1:0] port_hit_s;
  logic [7:0]           rd_s;
  logic [W-1:0]         clr_s;
  logic [W-1:0]         edge_raw_s;
  logic [W-1:0]         edge_s;

  function automatic logic [7:0] port_read(input logic [1:0] r, input logic [7:0] o,
                                           input logic [7:0] d, input logic [7:0] f,
                                           input logic [7:0] e, input logic [7:0] s);
    case (r)
      2'd0:    port_read = (d & o) | (~d & s);
      2'd1:    port_read = d;
      2'd2:    port_read = f;
      2'd3:    port_read = e;
      default: port_read = 8'h00;
    endcase
  endfunction

  // Address decode, read-data mux and flag-clear mask
  always_comb begin
    sel_s      = (addr[15:5] == BASE_ADDR[15:5]) && ({1'b0, addr[4:2]} < NP_W);
    port_hit_s = {NUM_PORTS{1'b0}};
    rd_s       = 8'h00;
    clr_s      = {W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_hit_s[i] = sel_s && (addr[4:2] == 3'(i));
      rd_s = rd_s | (port_hit_s[i] ?
                     port_read(addr[1:0], out_r[8*i +: 8], dir_r[8*i +: 8],
                               flag_r[8*i +: 8], ien_r[8*i +: 8], sync_r[8*i +: 8]) : 8'h00);
      clr_s[8*i +: 8] = (write_enable && port_hit_s[i] && (addr[1:0] == 2'd2)) ?
                        data_in : 8'h00;
    end
  end

  generate
    if (EDGE_MODE != 0) begin : g_any_edge
      assign edge_raw_s = sync_r ^ prev_r;
    end else begin : g_rise_edge
      assign edge_raw_s = sync_r & ~prev_r;
    end
  endgenerate

  // Edges are masked until the synchroniser has flushed its post-reset zeros
  assign edge_s   = (settle_r == 2'd3) ? edge_raw_s : {W{1'b0}};
  assign port_out = out_r;
  assign port_dir = dir_r;

  // Register file, pin synchroniser, flags, read pipeline and interrupt
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      out_r    <= {W{1'b0}};
      dir_r    <= {W{1'b0}};
      flag_r   <= {W{1'b0}};
      ien_r    <= {W{1'b0}};
      sync1_r  <= {W{1'b0}};
      sync_r   <= {W{1'b0}};
      prev_r   <= {W{1'b0}};
      settle_r <= 2'd0;
      data_out <= 8'h00;
      hit      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      sync1_r  <= port_in;
      sync_r   <= sync1_r;
      prev_r   <= sync_r;
      if (settle_r != 2'd3) begin
        settle_r <= settle_r + 2'd1;
      end
      // A fresh edge wins over a same-cycle clear
      flag_r   <= (flag_r & ~clr_s) | edge_s;
      irq      <= |(flag_r & ien_r);
      hit      <= sel_s;
      data_out <= rd_s;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (write_enable && port_hit_s[i]) begin
          case (addr[1:0])
            2'd0:    out_r[8*i +: 8] <= data_in;
            2'd1:    dir_r[8*i +: 8] <= data_in;
            2'd3:    ien_r[8*i +: 8] <= data_in;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (NUM_PORTS=2, rising-edge flags).
module tb_io_port_bank;

  localparam int NP = 2;

  logic            cpu_clk;
  logic            reset;
  logic [15:0]     addr;
  logic [7:0]      data_in;
  logic            write_enable;
  logic [7:0]      data_out;
  logic            hit;
  logic [8*NP-1:0] port_in;
  logic [8*NP-1:0] port_out;
  logic [8*NP-1:0] port_dir;
  logic            irq;

  int n_cmp;
  int n_err;

  io_port_bank #(.BASE_ADDR(16'h8400), .NUM_PORTS(NP), .EDGE_MODE(0)) dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .hit          (hit),
    .port_in      (port_in),
    .port_out     (port_out),
    .port_dir     (port_dir),
    .irq          (irq)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    addr         = 16'h0000;
    data_in      = 8'h00;
    write_enable = 1'b0;
    port_in      = 16'h0000;
    tick();
    tick();
    check("rst_port_out", port_out, 16'h0000);
    check("rst_port_dir", port_dir, 16'h0000);
    check("rst_data_out", {8'h00, data_out}, 16'h0000);
    check("rst_hit", {15'h0000, hit}, 16'h0000);
    check("rst_irq", {15'h0000, irq}, 16'h0000);
    reset = 1'b0;

    // Port 0 write OUT=A5, DIR=FF, then read back
    addr = 16'h8400; data_in = 8'hA5; write_enable = 1'b1;
    tick();
    addr = 16'h8401; data_in = 8'hFF;
    tick();
    write_enable = 1'b0;
    check("wr_out0", {8'h00, port_out[7:0]}, 16'h00A5);
    check("wr_dir0", {8'h00, port_dir[7:0]}, 16'h00FF);
    addr = 16'h8400;
    tick();
    check("rd_data0", {8'h00, data_out}, 16'h00A5);
    check("rd_hit0", {15'h0000, hit}, 16'h0001);

    // Read-during-write returns the old value
    data_in = 8'h3C; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    check("rdw_old", {8'h00, data_out}, 16'h00A5);
    check("rdw_out0", {8'h00, port_out[7:0]}, 16'h003C);
    tick();
    check("rdw_new", {8'h00, data_out}, 16'h003C);

    // Port 1 mixed direction: DIR=0F, OUT=03, pins C0
    addr = 16'h8405; data_in = 8'h0F; write_enable = 1'b1;
    tick();
    addr = 16'h8404; data_in = 8'h03;
    tick();
    write_enable = 1'b0;
    port_in[15:8] = 8'hC0;
    tick();
    tick();
    tick();
    tick();
    check("rd_mixed1", {8'h00, data_out}, 16'h00C3);
    addr = 16'h8405;
    tick();
    check("rd_dir1", {8'h00, data_out}, 16'h000F);
    addr = 16'h8406;
    tick();
    check("rd_flag1", {8'h00, data_out}, 16'h00C0);
    check("irq_no_ien1", {15'h0000, irq}, 16'h0000);

    // Rising edge on port0 bit0 with IEN0=01: flag on 3rd edge, irq on 4th
    addr = 16'h8403; data_in = 8'h01; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    addr = 16'h8402;
    port_in[0] = 1'b1;
    tick();
    check("edge_irq_t1", {15'h0000, irq}, 16'h0000);
    tick();
    check("edge_irq_t2", {15'h0000, irq}, 16'h0000);
    tick();
    check("edge_irq_t3", {15'h0000, irq}, 16'h0000);
    check("edge_flag_t3", {8'h00, data_out}, 16'h0000);
    tick();
    check("edge_irq_t4", {15'h0000, irq}, 16'h0001);
    check("edge_flag_t4", {8'h00, data_out}, 16'h0001);

    // W1C clears flag, irq drops one cycle later
    data_in = 8'h01; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    check("w1c_irq_same", {15'h0000, irq}, 16'h0001);
    tick();
    check("w1c_irq_after", {15'h0000, irq}, 16'h0000);
    check("w1c_flag", {8'h00, data_out}, 16'h0000);

    // Falling edge raises nothing in rising mode
    port_in[0] = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("fall_no_flag", {8'h00, data_out}, 16'h0000);

    // Same-cycle clear and new edge: set wins
    port_in[0] = 1'b1;
    tick();
    tick();
    data_in = 8'h01; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    check("race_irq_t3", {15'h0000, irq}, 16'h0000);
    tick();
    check("race_flag", {8'h00, data_out}, 16'h0001);
    check("race_irq_t4", {15'h0000, irq}, 16'h0001);
    data_in = 8'h01; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    tick();
    check("race_clr_flag", {8'h00, data_out}, 16'h0000);

    // Unselected addresses inside and outside the window
    addr = 16'h8408; data_in = 8'h55; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    check("oob_hit_wr", {15'h0000, hit}, 16'h0000);
    check("oob_data_wr", {8'h00, data_out}, 16'h0000);
    tick();
    check("oob_hit_rd", {15'h0000, hit}, 16'h0000);
    check("oob_data_rd", {8'h00, data_out}, 16'h0000);
    check("oob_port_out", port_out, 16'h033C);
    check("oob_port_dir", port_dir, 16'h0FFF);
    addr = 16'h8000;
    tick();
    check("far_hit", {15'h0000, hit}, 16'h0000);
    check("far_data", {8'h00, data_out}, 16'h0000);

    // Pins high across reset must not raise flags after release
    port_in = 16'hFFFF;
    reset   = 1'b1;
    addr    = 16'h8402;
    tick();
    tick();
    check("rst2_port_out", port_out, 16'h0000);
    check("rst2_irq", {15'h0000, irq}, 16'h0000);
    check("rst2_hit", {15'h0000, hit}, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("settle_flag0", {8'h00, data_out}, 16'h0000);
    end
    addr = 16'h8406;
    tick();
    check("settle_flag1", {8'h00, data_out}, 16'h0000);
    addr = 16'h8403;
    tick();
    check("rst2_ien0", {8'h00, data_out}, 16'h0000);
    check("settle_irq", {15'h0000, irq}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
